// File: rtl/exibe_sequencia_if.sv
// LED/button interface between the game controller, the sequence memory
// and the sequence presenter. The presenter is the slave side: it takes the
// start request, the last-item index and the memory data, and drives the
// memory address, the LEDs and the status outputs.
interface exibe_sequencia_if;
   logic       iniciar;
   logic [3:0] ultimo;
   logic [3:0] dado;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       exibindo;
   logic       pronto;
   logic [3:0] db_estado;

   modport master (
      output iniciar, ultimo, dado,
      input  endereco, leds, exibindo, pronto, db_estado
   );

   modport slave (
      input  iniciar, ultimo, dado,
      output endereco, leds, exibindo, pronto, db_estado
   );
endinterface

// File: rtl/exibe_sequencia.sv
// Sequence presenter for the memory game. On a start request it walks the
// sequence memory from address 0 to the captured last index, showing each
// item on the LEDs for TEMPO_ON cycles followed by TEMPO_OFF dark cycles,
// then pulses pronto for one cycle. Every output is either a register or a
// decode of the registered state, so dado never reaches leds combinationally.
module exibe_sequencia #(
   parameter int TEMPO_ON  = 3,
   parameter int TEMPO_OFF = 2
) (
   input logic          clock,
   input logic          reset,
   exibe_sequencia_if.slave bus
);

   localparam int TEMPO_MAX = (TEMPO_ON > TEMPO_OFF) ? TEMPO_ON : TEMPO_OFF;
   localparam int TIMER_W   = (TEMPO_MAX > 1) ? $clog2(TEMPO_MAX) : 1;

   localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(TEMPO_ON - 1);
   localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(TEMPO_OFF - 1);

   typedef enum logic [2:0] {
      INICIAL = 3'd0,
      PREPARA = 3'd1,
      CARREGA = 3'd2,
      ACENDE  = 3'd3,
      APAGA   = 3'd4,
      PROXIMO = 3'd5,
      FIM     = 3'd6
   } estado_t;

   estado_t            estado;
   estado_t            estado_prox;
   logic [3:0]         endereco;
   logic [3:0]         ultimo_reg;
   logic [3:0]         led_reg;
   logic [TIMER_W-1:0] timer;

   logic               fim_aceso;
   logic               fim_apagado;
   logic               ultimo_item;

   assign fim_aceso   = (timer == ON_LAST);
   assign fim_apagado = (timer == OFF_LAST);
   assign ultimo_item = (endereco == ultimo_reg);

   // State register; reset overrides every transition.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado <= INICIAL;
      end else begin
         estado <= estado_prox;
      end
   end

   // Next-state decode; iniciar is only looked at while idle.
   always_comb begin
      estado_prox = estado;
      case (estado)
         INICIAL: if (bus.iniciar) estado_prox = PREPARA;
         PREPARA: estado_prox = CARREGA;
         CARREGA: estado_prox = ACENDE;
         ACENDE:  if (fim_aceso) estado_prox = APAGA;
         APAGA: begin
            if (fim_apagado) begin
               estado_prox = ultimo_item ? FIM : PROXIMO;
            end
         end
         PROXIMO: estado_prox = CARREGA;
         FIM:     estado_prox = INICIAL;
         default: estado_prox = INICIAL;
      endcase
   end

   // Address counter, captured last index, LED register and phase timer.
   // Updates take effect on leaving the state, so the address is already
   // stable during the whole CARREGA cycle that latches dado.
   always_ff @(posedge clock) begin
      if (reset) begin
         endereco   <= '0;
         ultimo_reg <= '0;
         led_reg    <= '0;
         timer      <= '0;
      end else begin
         case (estado)
            PREPARA: begin
               endereco   <= '0;
               ultimo_reg <= bus.ultimo;
               timer      <= '0;
            end
            CARREGA: begin
               led_reg <= bus.dado;
            end
            ACENDE: begin
               timer <= fim_aceso ? '0 : timer + 1'b1;
            end
            APAGA: begin
               timer <= fim_apagado ? '0 : timer + 1'b1;
            end
            PROXIMO: begin
               endereco <= endereco + 4'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // Output decode from the registered state and registers only.
   always_comb begin
      bus.leds      = (estado == ACENDE) ? led_reg : 4'd0;
      bus.exibindo  = (estado != INICIAL) && (estado != FIM);
      bus.pronto    = (estado == FIM);
      bus.db_estado = {1'b0, estado};
      bus.endereco  = endereco;
   end

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia: a cycle-plan model predicts every output each
// cycle, plus directed scenarios with hand-computed cycle numbers.
module tb_exibe_sequencia;
   localparam int TON  = 3;
   localparam int TOFF = 2;

   logic clock = 1'b0;
   logic reset;

   exibe_sequencia_if bus ();

   exibe_sequencia #(
      .TEMPO_ON  (TON),
      .TEMPO_OFF (TOFF)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Sequence memory with combinational read.
   logic [3:0] mem [16];
   assign bus.dado = mem[bus.endereco];

   typedef struct packed {
      logic [3:0] est;
      logic [3:0] leds;
      logic [3:0] addr;
   } cyc_t;

   cyc_t plan [$];
   cyc_t cur;
   bit   model_ok = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Expand a whole playback into its cycle-by-cycle expected outputs.
   task automatic build(input logic [3:0] held, input logic [3:0] last);
      int n;
      n = int'(last) + 1;
      plan.push_back('{4'd1, 4'd0, held});
      for (int i = 0; i < n; i++) begin
         plan.push_back('{4'd2, 4'd0, 4'(i)});
         repeat (TON)  plan.push_back('{4'd3, mem[i], 4'(i)});
         repeat (TOFF) plan.push_back('{4'd4, 4'd0, 4'(i)});
         if (i < n - 1) plan.push_back('{4'd5, 4'd0, 4'(i)});
      end
      plan.push_back('{4'd6, 4'd0, 4'(n - 1)});
   endtask

   // Model: advance one cycle of the expected plan on each clock edge.
   always @(posedge clock) begin : model
      cyc_t nxt;
      if (reset) begin
         plan.delete();
         nxt = '{4'd0, 4'd0, 4'd0};
      end else if (plan.size() > 0) begin
         nxt = plan.pop_front();
      end else if (cur.est == 4'd0 && bus.iniciar) begin
         build(cur.addr, bus.ultimo);
         nxt = plan.pop_front();
      end else begin
         nxt = '{4'd0, 4'd0, cur.addr};
      end
      cur      <= nxt;
      model_ok <= model_ok | reset;
   end

   // Compare every output against the model on the falling edge.
   always @(negedge clock) begin
      if (model_ok) begin
         chk("db_estado", bus.db_estado, cur.est);
         chk("leds", bus.leds, cur.leds);
         chk("endereco", bus.endereco, cur.addr);
         chk("pronto", bus.pronto, cur.est == 4'd6);
         chk("exibindo", bus.exibindo, cur.est != 4'd0 && cur.est != 4'd6);
      end
   end

   initial begin
      int pr_cyc, pr_cnt, lit_cnt, prox_seen, exp_addr, bad, end_addr;
      for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
      reset       = 1'b1;
      bus.iniciar = 1'b0;
      bus.ultimo  = 4'd0;

      // Reset values and staying idle.
      repeat (2) @(negedge clock);
      chk("rst_db_estado", bus.db_estado, 0);
      chk("rst_leds", bus.leds, 0);
      chk("rst_endereco", bus.endereco, 0);
      chk("rst_pronto", bus.pronto, 0);
      chk("rst_exibindo", bus.exibindo, 0);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      chk("idle_db_estado", bus.db_estado, 0);

      // Two-item playback.
      mem[0] = 4'b0001;
      mem[1] = 4'b0100;
      bus.ultimo  = 4'd1;
      bus.iniciar = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clock);
         if (c == 1) bus.iniciar = 1'b0;
         if (c == 1) chk("two_db_c1", bus.db_estado, 1);
         if (c == 2) chk("two_db_c2", bus.db_estado, 2);
         if (c >= 3 && c <= 5) chk("two_leds_item0", bus.leds, 4'b0001);
         if (c >= 6 && c <= 8) chk("two_leds_dark0", bus.leds, 0);
         if (c >= 9 && c <= 15) chk("two_endereco1", bus.endereco, 1);
         if (c >= 10 && c <= 12) chk("two_leds_item1", bus.leds, 4'b0100);
         if (c == 13 || c == 14) chk("two_leds_dark1", bus.leds, 0);
         chk("two_pronto", bus.pronto, c == 15);
         if (c == 16) chk("two_db_c16", bus.db_estado, 0);
      end

      // Single item.
      mem[0] = 4'b1000;
      bus.ultimo  = 4'd0;
      bus.iniciar = 1'b1;
      pr_cyc = 0; lit_cnt = 0; prox_seen = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         if (c == 1) bus.iniciar = 1'b0;
         if (bus.leds == 4'b1000) lit_cnt++;
         if (bus.db_estado == 4'd5) prox_seen++;
         if (bus.pronto === 1'b1 && pr_cyc == 0) pr_cyc = c;
      end
      chk("single_lit_cycles", lit_cnt, 3);
      chk("single_no_proximo", prox_seen, 0);
      chk("single_pronto_cycle", pr_cyc, 8);

      // Full length, with ultimo changed mid-playback.
      for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
      bus.ultimo  = 4'd15;
      bus.iniciar = 1'b1;
      pr_cyc = 0; exp_addr = 0; bad = 0; end_addr = 0;
      for (int c = 1; c <= 116; c++) begin
         @(negedge clock);
         if (c == 1) bus.iniciar = 1'b0;
         if (c == 20) bus.ultimo = 4'd2;
         if (bus.db_estado == 4'd2) begin
            if (bus.endereco !== 4'(exp_addr)) bad++;
            exp_addr++;
         end
         if (bus.pronto === 1'b1 && pr_cyc == 0) begin
            pr_cyc   = c;
            end_addr = int'(bus.endereco);
         end
      end
      chk("full_items_visited", exp_addr, 16);
      chk("full_visit_order", bad, 0);
      chk("full_pronto_cycle", pr_cyc, 113);
      chk("full_final_endereco", end_addr, 15);

      // Reset during ACENDE of the third item, then restart.
      bus.ultimo  = 4'd3;
      bus.iniciar = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clock);
         if (c == 1) bus.iniciar = 1'b0;
      end
      chk("midrst_in_acende", bus.db_estado, 3);
      chk("midrst_item3_addr", bus.endereco, 2);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_db_estado", bus.db_estado, 0);
      chk("midrst_leds", bus.leds, 0);
      chk("midrst_pronto", bus.pronto, 0);
      reset = 1'b0;
      bus.iniciar = 1'b1;
      pr_cyc = 0;
      for (int c = 1; c <= 32; c++) begin
         @(negedge clock);
         if (c == 1) bus.iniciar = 1'b0;
         if (c == 2) chk("restart_endereco0", bus.endereco, 0);
         if (c == 3) chk("restart_leds0", bus.leds, mem[0]);
         if (bus.pronto === 1'b1 && pr_cyc == 0) pr_cyc = c;
      end
      chk("restart_pronto_cycle", pr_cyc, 29);

      // iniciar held high: back-to-back single-item playbacks.
      mem[0] = 4'b0010;
      bus.ultimo  = 4'd0;
      bus.iniciar = 1'b1;
      pr_cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clock);
         if (c <= 9 && bus.pronto === 1'b1) pr_cnt++;
         if (c == 10) chk("held_reenter_prepara", bus.db_estado, 1);
         if (c == 17) chk("held_second_pronto", bus.pronto, 1);
      end
      chk("held_single_pronto", pr_cnt, 1);
      bus.iniciar = 1'b0;
      repeat (12) @(negedge clock);
      chk("final_idle", bus.db_estado, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
